// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier.
// One multiplier bit per cycle, valid/ready on both sides.
module mul_seq #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [2*W-1:0] out_p
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] sum;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           accept;

  assign last   = (cnt == CNT_LAST);
  assign accept = (state == IDLE) && in_vld;
  assign sum    = mplier[0] ? acc + mcand : acc;
  assign out_p  = prod;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshake outputs, state-only decode
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath; prod keeps the last finished result
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod   <= '0;
    end else if (accept) begin
      mcand  <= {{W{1'b0}}, in_a};
      mplier <= in_b;
      acc    <= '0;
      cnt    <= CNT_INIT;
    end else if (state == BUSY) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_LAST;
      if (last) prod <= sum;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq at W=8.
// Directed vectors, monitor checks every output handshake.
module tb_mul_seq;

  localparam int W = 8;

  logic           clk;
  logic           arst_n;
  logic           in_vld;
  logic           in_rdy;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_vld;
  logic           out_rdy;
  logic [2*W-1:0] out_p;

  int n_cmp;
  int n_bad;
  int cyc;
  int n_xfer;
  bit prev_vld;
  logic [2*W-1:0] exp_q[$];
  int lat_q[$];

  mul_seq #(.W(W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .in_a   (in_a),
    .in_b   (in_b),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_p  (out_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: latency on rise, product on each handshake
  always @(negedge clk) begin
    if (arst_n) begin
      if (out_vld && !prev_vld) begin
        if (lat_q.size() == 0) begin
          chk("unexpected_vld", 32'(out_vld), 32'd0);
        end else begin
          chk("latency", 32'(cyc - lat_q[0]), 32'(W));
        end
      end
      if (out_vld && out_rdy) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'(out_vld), 32'd0);
        end else begin
          chk("product", 32'(out_p), 32'(exp_q.pop_front()));
          if (lat_q.size() != 0) void'(lat_q.pop_front());
        end
      end
      if (in_vld && in_rdy) lat_q.push_back(cyc + 1);
    end
    prev_vld = out_vld;
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                      logic [2*W-1:0] e);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_vld = 1'b1;
    while (!in_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_rdy", 32'(in_rdy), 32'd1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    int x0;
    int first;
    int second;
    int n;
    int seen;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    n_xfer = 0;
    prev_vld = 1'b0;
    arst_n = 1'b0;
    in_vld = 1'b0;
    in_a = '0;
    in_b = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'h0000);
    @(posedge clk); #1;

    // Max operands
    send(8'hFF, 8'hFF, 16'hFE01);
    wait_done();
    chk("max_back_idle", 32'(in_rdy), 32'd1);

    // Zero and identity
    send(8'h00, 8'hA5, 16'h0000);
    wait_done();
    send(8'h37, 8'h01, 16'h0037);
    wait_done();

    // Backpressure
    out_rdy = 1'b0;
    send(8'h12, 8'h34, 16'h03A8);
    n = 0;
    while (!out_vld && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    x0 = n_xfer;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_vld", 32'(out_vld), 32'd1);
      chk("bp_p", 32'(out_p), 32'h03A8);
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_one_xfer", 32'(n_xfer - x0), 32'd1);
    chk("bp_vld_drop", 32'(out_vld), 32'd0);
    wait_done();

    // Requests ignored while busy
    in_a = 8'h11;
    in_b = 8'h22;
    in_vld = 1'b1;
    first = cyc + 1;
    exp_q.push_back(16'h0242);
    @(posedge clk); #1;
    n = 0;
    while (!in_rdy && n < 30) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_a = 8'h05;
    in_b = 8'h06;
    second = cyc + 1;
    exp_q.push_back(16'h001E);
    chk("init_interval", 32'(second - first), 32'(W + 2));
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_done();

    // Reset in the middle of an operation
    send(8'hFF, 8'h80, 16'h7F80);
    repeat (3) @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_out_p", 32'(out_p), 32'h0000);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_vld) seen++;
    end
    chk("no_vld_after_rst", 32'(seen), 32'd0);
    send(8'h02, 8'h03, 16'h0006);
    wait_done();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative unsigned shift-add multiplier: accepts two W-bit operands over a valid/ready handshake and returns the 2W-bit product one bit of multiplier per cycle. It is the runtime inverse of the `math_pkg::div_ceil` sizing arithmetic: it rebuilds totals from per-unit counts, e.g. beats × bytes-per-beat, for datapaths where a full-width combinational multiplier is too costly. It sits between a request producer and a consumer, and both sides may stall.

## Interface
- `W`, default 32: operand width; legal range W ≥ 2.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `arst_n`  in  1: asynchronous active-low reset; deassertion synchronous to `clk` externally.
- `in_vld`  in  1: operand request valid.
- `in_rdy`  out  1: block can accept operands.
- `in_a`  in  W: multiplicand, unsigned.
- `in_b`  in  W: multiplier, unsigned.
- `out_vld`  out  1: product valid.
- `out_rdy`  in  1: consumer accepts product.
- `out_p`  out  2W: product `in_a * in_b`, exact, no truncation.

## Operation
- FSM states:
  - `IDLE`: `in_rdy`=1.
  - `BUSY`: iterating.
  - `DONE`: `out_vld`=1.
- `in_rdy` is a function of state only; it is 1 iff in `IDLE`.
- `out_vld` is 1 iff in `DONE`.
- Accept occurs on an edge where `in_vld && in_rdy`:
  - mcand ← zero-extend(`in_a`) to 2W.
  - mplier ← `in_b`.
  - acc ← 0.
  - cnt ← W.
  - state ← `BUSY`.
- Each `BUSY` cycle:
  - If mplier[0], acc ← acc + mcand (2W-bit add, no overflow possible).
  - mcand ← mcand << 1.
  - mplier ← mplier >> 1.
  - cnt ← cnt − 1.
  - When cnt is 1 on that edge, state ← `DONE`.
- There is no early termination: the iteration count is always W, independent of the operand values.
- `DONE`:
  - `out_p` = acc and is held stable while `out_vld && !out_rdy`.
  - On `out_vld && out_rdy`, state ← `IDLE`.
- `in_vld` is ignored in `BUSY` and `DONE`. Inputs are sampled only on the accept edge, so later changes to `in_a`/`in_b` have no effect.
- `out_p` in `IDLE`/`BUSY` holds the last completed product (0 after reset). Consumers must qualify it with `out_vld`.
- `cnt` width is `$clog2(W+1)`.
- Asynchronous reset in any state:
  - state ← `IDLE`, acc ← 0, cnt ← 0.
  - Any in-flight operation is discarded and no product is emitted.

## Timing
- Reset values: `in_rdy`=1, `out_vld`=0, `out_p`=0.
- Latency: accept on edge k → `out_vld` rises after edge k+W, i.e. exactly W cycles.
- Minimum initiation interval is W+2 cycles:
  - accept edge,
  - W `BUSY` edges,
  - output handshake edge,
  - next accept can occur no earlier than the following edge, because `in_rdy` is low during the handshake cycle.
- There is no combinational path from `in_vld` to `in_rdy` or from `out_rdy` to `out_vld`.
- Backpressure: `out_rdy` low holds `DONE` indefinitely with `out_p` unchanged.

## Test plan
- Use W=8 for all scenarios.
- Reset then idle: after `arst_n` release, `in_rdy`=1, `out_vld`=0, `out_p`=0x0000.
- Max operands: a=0xFF, b=0xFF, `out_rdy`=1 → `out_vld` exactly 8 cycles after accept, `out_p`=0xFE01, then back to `IDLE`.
- Zero and identity:
  - a=0x00, b=0xA5 → 0x0000.
  - a=0x37, b=0x01 → 0x0037.
  - Both complete with identical 8-cycle latency.
- Backpressure: a=0x12, b=0x34 with `out_rdy`=0 for 5 cycles → `out_vld` held, `out_p`=0x03A8 stable, `in_rdy`=0; on `out_rdy`=1, a single transfer occurs.
- Ignored requests: `in_vld` held high with changing `in_a`/`in_b` throughout `BUSY` → result reflects only the accept-edge operands, and the next accept happens no sooner than 10 cycles after the first.
- Reset mid-op: assert `arst_n`=0 at iteration 4 of a=0xFF, b=0x80 → outputs immediately at reset values, no `out_vld` afterward. A new request a=0x02, b=0x03 after release → 0x0006.
